// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_pkg                                               |
// | Description : Shared constants, receiver state codes and helpers    |
// |               for the parametrised UART blocks.                      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package uart_pkg;

   // Parity modes
   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Receiver FSM state codes
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   // Width of a counter that must hold values 0..div-1
   function automatic int cnt_width(input int div);
      return (div < 2) ? 1 : $clog2(div);
   endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_baud_cnt                                          |
// | Description : Per-bit down-counter producing a mid-bit sample strobe |
// |               and a bit-end strobe. Reloads itself at bit end.       |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int CLK_DIV = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic enable,
   output logic sample,
   output logic bit_end
);

   localparam int             c_cw     = cnt_width(CLK_DIV);
   localparam logic [c_cw-1:0] c_reload = c_cw'(CLK_DIV - 1);
   localparam logic [c_cw-1:0] c_mid    = c_cw'(CLK_DIV / 2);

   logic [c_cw-1:0] r_cnt;

   // Count down once per clk; reaching zero starts the next bit period
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= c_reload;
      end else if (enable) begin
         r_cnt <= (r_cnt == '0) ? c_reload : r_cnt - 1'b1;
      end
   end

   assign sample  = enable && !load && (r_cnt == c_mid);
   assign bit_end = enable && !load && (r_cnt == '0);

endmodule : uart_baud_cnt
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_rx_param                                          |
// | Description : Parametrised UART receiver with synchroniser, own baud |
// |               timing, parity/stop checking and a valid/ready holding |
// |               register with overrun flagging.                        |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLK_DIV     = 16,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 uart_din,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 rx_busy
);

   localparam logic [3:0]          c_data_bits = 4'(DATA_BITS);
   localparam logic                c_last_stop = 1'(STOP_BITS - 1);
   localparam int                  c_warm_w    = $clog2(SYNC_STAGES + 2);
   localparam logic [c_warm_w-1:0] c_warm_max  = c_warm_w'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_line_d;
   logic [c_warm_w-1:0]    r_warm;
   logic [2:0]             r_state;
   logic [3:0]             r_bit_cnt;
   logic                   r_stop_cnt;
   logic [DATA_BITS-1:0]   r_shift;
   logic                   r_perr;
   logic                   r_ferr;

   logic w_line;
   logic w_fall;
   logic w_load;
   logic w_enable;
   logic w_sample;
   logic w_bit_end;
   logic w_par_exp;
   logic w_done;
   logic w_accept;

   assign w_line = r_sync[SYNC_STAGES-1];

   // Synchroniser chain plus edge history; edges are only trusted once the
   // chain has been flushed with real pad values after reset, so a line that
   // is low at reset release is not mistaken for a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync   <= '1;
         r_line_d <= 1'b1;
         r_warm   <= '0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], uart_din};
         r_line_d <= w_line;
         if (r_warm != c_warm_max) begin
            r_warm <= r_warm + 1'b1;
         end
      end
   end

   assign w_fall   = (r_warm == c_warm_max) && r_line_d && !w_line;
   assign w_load   = (r_state == ST_IDLE) && w_fall;
   assign w_enable = (r_state != ST_IDLE);
   assign rx_busy  = (r_state != ST_IDLE);

   uart_baud_cnt #(
      .CLK_DIV (CLK_DIV)
   ) u_baud (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (w_load),
      .enable  (w_enable),
      .sample  (w_sample),
      .bit_end (w_bit_end)
   );

   generate
      if (PARITY == PAR_ODD) begin : g_par_odd
         assign w_par_exp = ~^r_shift;
      end else begin : g_par_even
         assign w_par_exp = ^r_shift;
      end
   endgenerate

   // Final stop sample completes the frame; the stop value seen now counts
   assign w_done   = (r_state == ST_STOP) && w_sample && (r_stop_cnt == c_last_stop);
   assign w_accept = rx_valid && rx_ready;

   // Frame FSM: start validation, data shift-in, parity and stop checking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_shift    <= '0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_fall) begin
                  r_state    <= ST_START;
                  r_bit_cnt  <= '0;
                  r_stop_cnt <= 1'b0;
                  r_perr     <= 1'b0;
                  r_ferr     <= 1'b0;
               end
            end
            ST_START: begin
               if (w_sample && w_line) begin
                  r_state <= ST_IDLE;
               end else if (w_bit_end) begin
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_sample) begin
                  r_shift   <= {w_line, r_shift[DATA_BITS-1:1]};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
               if (w_bit_end && (r_bit_cnt == c_data_bits)) begin
                  r_bit_cnt <= '0;
                  r_state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
               end
            end
            ST_PARITY: begin
               if (w_sample) begin
                  r_perr <= (w_line != w_par_exp);
               end
               if (w_bit_end) begin
                  r_state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (w_sample) begin
                  if (!w_line) begin
                     r_ferr <= 1'b1;
                  end
                  if (r_stop_cnt == c_last_stop) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_stop_cnt <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Holding register: load on completion if empty or being drained, else drop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (w_done) begin
            if (!rx_valid || w_accept) begin
               rx_data    <= r_shift;
               parity_err <= r_perr;
               frame_err  <= r_ferr || !w_line;
               rx_valid   <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (w_accept) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule : uart_rx_param
`default_nettype wire
